// File: rtl/profile_pkg.sv
// Shared definitions for the profiling window controller: opcodes, FSM encoding and error word.
package profile_pkg;

    typedef enum logic [2:0] {
        OP_READ   = 3'd0,
        OP_CONFIG = 3'd1,
        OP_WINDOW = 3'd2,
        OP_ARM    = 3'd3,
        OP_STOP   = 3'd4,
        OP_STATUS = 3'd5,
        OP_CLEAR  = 3'd6,
        OP_RSVD   = 3'd7
    } prof_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } prof_state_e;

    localparam logic [31:0] PROF_ERR = 32'hFFFF_FFFF;
    localparam int unsigned NUM_CNT  = 4;

    function automatic logic [31:0] status_word(logic [3:0] ovf, prof_state_e st);
        return {20'b0, ovf, 2'b0, st, 4'b0};
    endfunction

endpackage

// File: rtl/profile_event_counter.sv
// 32-bit event counter with synchronous clear and a sticky wrap flag.
module profile_event_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] value,
    output logic        ovf
);

    logic [31:0] count;
    logic        ovf_flag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            ovf_flag <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            ovf_flag <= 1'b0;
        end else if (enable) begin
            count <= count + 32'd1;
            if (count == 32'hFFFF_FFFF) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    assign value = count;
    assign ovf   = ovf_flag;

endmodule

// File: rtl/profile_window_ctrl.sv
// CI-bus profiling controller: maps event lines onto four counters and gates them with a
// trigger-started, cycle-budgeted measurement window.
module profile_window_ctrl
    import profile_pkg::*;
#(
    parameter logic [7:0]  customId   = 8'd9,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            ciN,
    input  logic [31:0]           valueA,
    input  logic [31:0]           valueB,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  trigger,
    output logic                  done,
    output logic [31:0]           result
);

    prof_state_e state;
    logic [2:0]  sel [NUM_CNT];
    logic [31:0] window_len;
    logic [31:0] remain;

    logic [31:0] cnt_val [NUM_CNT];
    logic [3:0]  ovf;
    logic [3:0]  cnt_en;
    logic        cnt_clear;

    logic        acc;
    prof_op_e    op;
    logic        cfg_ok;
    logic        count_en;
    logic [7:0]  ev_ext;
    logic        unused_bits;

    assign acc         = start && (ciN == customId);
    assign op          = prof_op_e'(valueA[2:0]);
    assign cfg_ok      = (state == ST_IDLE) || (state == ST_DONE);
    assign unused_bits = ^valueA[31:3];

    // The trigger cycle itself is the first counted cycle of the window.
    assign count_en  = (state == ST_RUNNING) || ((state == ST_ARMED) && trigger);
    assign cnt_clear = acc && ((op == OP_ARM) || (op == OP_CLEAR));

    // Selects beyond the wired event lines read as constant 1 so the counter counts cycles.
    always_comb begin
        ev_ext                   = '1;
        ev_ext[NUM_EVENTS-1:0]   = events;
    end

    always_comb begin
        cnt_en = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_en[i] = count_en && ev_ext[sel[i]];
        end
    end

    profile_event_counter u_cnt0 (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en[0]),
        .value  (cnt_val[0]),
        .ovf    (ovf[0])
    );

    profile_event_counter u_cnt1 (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en[1]),
        .value  (cnt_val[1]),
        .ovf    (ovf[1])
    );

    profile_event_counter u_cnt2 (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en[2]),
        .value  (cnt_val[2]),
        .ovf    (ovf[2])
    );

    profile_event_counter u_cnt3 (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en[3]),
        .value  (cnt_val[3]),
        .ovf    (ovf[3])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            window_len <= '0;
            remain     <= '0;
            done       <= 1'b0;
            result     <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                sel[i] <= 3'(i);
            end
        end else begin
            done   <= acc;
            result <= '0;

            // Window progression; CI commands below take precedence on the same edge.
            unique case (state)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (trigger) begin
                        if (window_len == 32'd1) begin
                            state <= ST_DONE;
                        end else begin
                            state  <= ST_RUNNING;
                            remain <= window_len - 32'd1;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (window_len != 32'd0) begin
                        if (remain == 32'd1) begin
                            state <= ST_DONE;
                        end else begin
                            remain <= remain - 32'd1;
                        end
                    end
                end
                ST_DONE: ;
            endcase

            if (acc) begin
                case (op)
                    OP_READ: result <= cnt_val[valueB[1:0]];
                    OP_CONFIG: begin
                        if (cfg_ok) begin
                            sel[valueB[1:0]] <= valueB[4:2];
                        end else begin
                            result <= PROF_ERR;
                        end
                    end
                    OP_WINDOW: begin
                        if (cfg_ok) begin
                            window_len <= valueB;
                        end else begin
                            result <= PROF_ERR;
                        end
                    end
                    OP_ARM: begin
                        if (valueB[0]) begin
                            state  <= ST_RUNNING;
                            remain <= window_len;
                        end else begin
                            state <= ST_ARMED;
                        end
                    end
                    OP_STOP: begin
                        if ((state == ST_ARMED) || (state == ST_RUNNING)) begin
                            state <= ST_DONE;
                        end
                    end
                    OP_STATUS: result <= status_word(ovf, state);
                    OP_CLEAR:  state  <= ST_IDLE;
                    default:   result <= PROF_ERR;
                endcase
            end
        end
    end

endmodule
